// File: rtl/scv_rominit_sink.sv
// Streams bytes from a loader into one of four ROM targets (boot, chr, apu, cart),
// checking address contiguity and capacity and reporting per-target completion.
module scv_rominit_sink #(
  parameter int CART_AW    = 17,
  parameter int BOOT_BYTES = 4096,
  parameter int CHR_BYTES  = 1024,
  parameter int APU_BYTES  = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_boot,
  input  logic               sel_chr,
  input  logic               sel_apu,
  input  logic               sel_cart,
  input  logic [24:0]        addr,
  input  logic [7:0]         data,
  input  logic               valid,
  output logic               boot_we,
  output logic               chr_we,
  output logic               apu_we,
  output logic               cart_we,
  output logic [CART_AW-1:0] waddr,
  output logic [7:0]         wdata,
  output logic               busy,
  output logic [3:0]         loaded,
  output logic               err,
  output logic [CART_AW:0]   cart_size
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam logic [CART_AW:0] CNT_MAX = {1'b1, {CART_AW{1'b0}}};

  state_t           state, state_nxt;
  logic [3:0]       sel, tgt, we_nxt;
  logic             one_hot, abort;
  logic             sess_err, suppress, idle_hold;
  logic             err_set, sess_err_set, suppress_set;
  logic [24:0]      prev_addr;
  logic [CART_AW:0] beat_cnt;

  // Capacity of a one-hot target vector, ordered {cart,apu,chr,boot}
  function automatic logic [25:0] cap_of(input logic [3:0] t);
    logic [25:0] c;
    c = '0;
    if (t[0]) c = 26'(BOOT_BYTES);
    if (t[1]) c = 26'(CHR_BYTES);
    if (t[2]) c = 26'(APU_BYTES);
    if (t[3]) c = 26'd1 << CART_AW;
    return c;
  endfunction

  assign sel     = {sel_cart, sel_apu, sel_chr, sel_boot};
  assign one_hot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign abort   = (sel != tgt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid && !idle_hold && one_hot) state_nxt = LOAD;
      LOAD:    if (!valid) state_nxt = IDLE;
               else if (abort) state_nxt = DRAIN;
      DRAIN:   if (!valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-beat decision: which strobe fires next cycle and which error flags to raise
  always_comb begin
    we_nxt       = '0;
    err_set      = 1'b0;
    sess_err_set = 1'b0;
    suppress_set = 1'b0;
    case (state)
      IDLE: if (valid && !idle_hold) begin
        if (!one_hot) begin
          err_set = 1'b1;
        end else if (addr != 25'd0) begin
          err_set      = 1'b1;
          sess_err_set = 1'b1;
          suppress_set = 1'b1;
        end else if ({1'b0, addr} >= cap_of(sel)) begin
          err_set      = 1'b1;
          sess_err_set = 1'b1;
        end else begin
          we_nxt = sel;
        end
      end
      LOAD: if (valid) begin
        if (abort) begin
          err_set = 1'b1;
        end else if (!suppress) begin
          if (addr != prev_addr + 25'd1) begin
            err_set      = 1'b1;
            sess_err_set = 1'b1;
            suppress_set = 1'b1;
          end else if ({1'b0, addr} >= cap_of(tgt)) begin
            err_set      = 1'b1;
            sess_err_set = 1'b1;
          end else begin
            we_nxt = tgt;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {cart_we, apu_we, chr_we, boot_we} <= '0;
      waddr     <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      loaded    <= '0;
      err       <= 1'b0;
      cart_size <= '0;
      tgt       <= '0;
      sess_err  <= 1'b0;
      suppress  <= 1'b0;
      idle_hold <= 1'b0;
      prev_addr <= '0;
      beat_cnt  <= '0;
    end else begin
      {cart_we, apu_we, chr_we, boot_we} <= we_nxt;
      if (|we_nxt) begin
        waddr <= addr[CART_AW-1:0];
        wdata <= data;
      end
      if (err_set) err <= 1'b1;
      // A malformed select in IDLE blocks new sessions until the stream goes quiet
      idle_hold <= (state == IDLE) && valid && (idle_hold || !one_hot);

      if (state == IDLE && state_nxt == LOAD) begin
        tgt       <= sel;
        busy      <= 1'b1;
        loaded    <= loaded & ~sel;
        sess_err  <= sess_err_set;
        suppress  <= suppress_set;
        prev_addr <= addr;
        beat_cnt  <= {{CART_AW{1'b0}}, 1'b1};
      end else if (state == LOAD && valid && !abort) begin
        sess_err  <= sess_err | sess_err_set;
        suppress  <= suppress | suppress_set;
        prev_addr <= addr;
        if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + 1'b1;
      end

      if (state != IDLE && state_nxt == IDLE) begin
        busy <= 1'b0;
        if (state == LOAD && !sess_err) begin
          loaded <= loaded | tgt;
          if (tgt[3]) cart_size <= beat_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_scv_rominit_sink.sv
// Randomized and directed bench for scv_rominit_sink, checked cycle by cycle
// against a session-level behavioural model of the loader protocol.
module tb_scv_rominit_sink;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    s_vec = '0;
  logic [24:0]   addr = '0;
  logic [7:0]    data = '0;
  logic          valid = 1'b0;
  logic          boot_we, chr_we, apu_we, cart_we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          busy, err;
  logic [3:0]    loaded;
  logic [AW:0]   cart_size;

  always #5 clk = ~clk;

  scv_rominit_sink dut (
    .clk(clk), .rst(rst),
    .sel_boot(s_vec[0]), .sel_chr(s_vec[1]), .sel_apu(s_vec[2]), .sel_cart(s_vec[3]),
    .addr(addr), .data(data), .valid(valid),
    .boot_we(boot_we), .chr_we(chr_we), .apu_we(apu_we), .cart_we(cart_we),
    .waddr(waddr), .wdata(wdata), .busy(busy), .loaded(loaded), .err(err),
    .cart_size(cart_size)
  );

  int checks = 0;
  int failures = 0;

  // Model of the loader: session flags plus the expected visible outputs
  bit         m_in, m_drain, m_hold, m_bad, m_supp;
  logic [3:0] m_tgt;
  int         m_cnt, m_last, m_cart;
  logic       m_busy, m_err;
  logic [3:0] m_loaded;
  logic [3:0] exp_we;
  int         exp_waddr, exp_wdata;
  int         m_wr[4];

  int bad_we, bad_data, bad_status;
  int we_cnt[4];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cap_of(input logic [3:0] s);
    case (s)
      4'b0001: return 4096;
      4'b0010: return 1024;
      4'b0100: return 2048;
      4'b1000: return 1 << AW;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_in = 0; m_drain = 0; m_hold = 0; m_bad = 0; m_supp = 0;
    m_tgt = '0; m_cnt = 0; m_last = 0; m_cart = 0;
    m_busy = 0; m_err = 0; m_loaded = '0; exp_we = '0;
    exp_waddr = 0; exp_wdata = 0;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    exp_we    = m_tgt;
    exp_waddr = a;
    exp_wdata = int'(d);
    for (int i = 0; i < 4; i++) if (m_tgt[i]) m_wr[i]++;
  endtask

  task automatic model_step(input logic v, input logic [3:0] s, input int a, input logic [7:0] d);
    exp_we = '0;
    if (m_in) begin
      if (!v) begin
        m_in = 0;
        m_busy = 0;
        if (!m_bad) begin
          m_loaded = m_loaded | m_tgt;
          if (m_tgt == 4'b1000) m_cart = m_cnt;
        end
      end else if (s != m_tgt) begin
        m_err = 1; m_in = 0; m_drain = 1;
      end else begin
        if (m_cnt < (1 << AW)) m_cnt++;
        if (!m_supp) begin
          if (a != m_last + 1) begin m_err = 1; m_bad = 1; m_supp = 1; end
          else if (a >= cap_of(m_tgt)) begin m_err = 1; m_bad = 1; end
          else model_write(a, d);
        end
        m_last = a;
      end
    end else if (m_drain) begin
      if (!v) begin m_drain = 0; m_busy = 0; end
    end else if (!v) begin
      m_hold = 0;
    end else if (!m_hold) begin
      if ($countones(s) == 1) begin
        m_in = 1; m_tgt = s; m_bad = 0; m_supp = 0; m_cnt = 1; m_last = a;
        m_busy = 1;
        m_loaded = m_loaded & ~s;
        if (a != 0) begin m_err = 1; m_bad = 1; m_supp = 1; end
        else if (a >= cap_of(s)) begin m_err = 1; m_bad = 1; end
        else model_write(a, d);
      end else begin
        m_err = 1; m_hold = 1;
      end
    end
  endtask

  // Outputs seen now belong to the beat driven one cycle earlier
  task automatic compare_prev();
    logic [3:0] obs;
    obs = {cart_we, apu_we, chr_we, boot_we};
    for (int i = 0; i < 4; i++) we_cnt[i] += int'(obs[i]);
    if (obs !== exp_we) bad_we++;
    if (exp_we != 4'd0 && (waddr !== exp_waddr[AW-1:0] || wdata !== exp_wdata[7:0])) bad_data++;
    if (busy !== m_busy || loaded !== m_loaded || err !== m_err || cart_size !== m_cart[AW:0])
      bad_status++;
  endtask

  task automatic apply_stimulus(input logic v, input logic [3:0] s, input int a, input logic [7:0] d);
    @(negedge clk);
    compare_prev();
    valid = v;
    s_vec = s;
    addr  = 25'(a);
    data  = d;
    model_step(v, s, a, d);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_output({pfx, ".we"}, {28'd0, cart_we, apu_we, chr_we, boot_we}, 0);
    check_output({pfx, ".waddr"}, waddr, 0);
    check_output({pfx, ".wdata"}, wdata, 0);
    check_output({pfx, ".busy"}, busy, 0);
    check_output({pfx, ".loaded"}, loaded, 0);
    check_output({pfx, ".err"}, err, 0);
    check_output({pfx, ".cart_size"}, cart_size, 0);
  endtask

  task automatic do_reset(input string pfx);
    @(negedge clk);
    compare_prev();
    valid = 1'b0;
    s_vec = '0;
    #2 rst = 1'b1;
    #1 check_reset_outputs(pfx);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic group_end(input string name, input int eb, input int ec, input int ea, input int ecart);
    repeat (2) apply_stimulus(1'b0, 4'($urandom), $urandom_range(0, 9), 8'($urandom));
    check_output({name, ".we_boot"}, we_cnt[0], eb);
    check_output({name, ".we_chr"}, we_cnt[1], ec);
    check_output({name, ".we_apu"}, we_cnt[2], ea);
    check_output({name, ".we_cart"}, we_cnt[3], ecart);
    check_output({name, ".bad_we_cycles"}, bad_we, 0);
    check_output({name, ".bad_wdata_cycles"}, bad_data, 0);
    check_output({name, ".bad_status_cycles"}, bad_status, 0);
    bad_we = 0; bad_data = 0; bad_status = 0;
    for (int i = 0; i < 4; i++) begin we_cnt[i] = 0; m_wr[i] = 0; end
  endtask

  task automatic random_session();
    logic [3:0] s, sb;
    int n, fault, k, a;
    case ($urandom_range(0, 5))
      0: s = 4'b0001;
      1: s = 4'b0010;
      2: s = 4'b0100;
      3: s = 4'b1000;
      4: s = 4'($urandom_range(0, 15));
      default: s = 4'b1000;
    endcase
    n = $urandom_range(1, 40);
    fault = $urandom_range(0, 5);
    k = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      a = i;
      sb = s;
      if (fault == 0 && i == 0) a = $urandom_range(1, 50);
      if (fault == 1 && k > 0 && i >= k) a = i + 2;
      if (fault == 2 && k > 0 && i >= k) sb = s ^ 4'(1 << $urandom_range(0, 3));
      apply_stimulus(1'b1, sb, a, 8'($urandom));
    end
    repeat ($urandom_range(1, 3)) apply_stimulus(1'b0, 4'($urandom), $urandom_range(0, 9), 8'($urandom));
  endtask

  initial begin
    int e0, e1, e2, e3;
    model_reset();
    bad_we = 0; bad_data = 0; bad_status = 0;
    for (int i = 0; i < 4; i++) begin we_cnt[i] = 0; m_wr[i] = 0; end

    #3 check_reset_outputs("init");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4096; i++) apply_stimulus(1'b1, 4'b0001, i, 8'(i));
    group_end("boot", 4096, 0, 0, 0);
    check_output("boot.loaded", loaded, 4'b0001);
    check_output("boot.err", err, 0);

    for (int i = 0; i < 32768; i++) apply_stimulus(1'b1, 4'b1000, i, 8'($urandom));
    group_end("cart", 0, 0, 0, 32768);
    check_output("cart.cart_size", cart_size, 32768);
    check_output("cart.loaded3", loaded[3], 1);
    check_output("cart.err", err, 0);

    for (int i = 0; i < 1030; i++) apply_stimulus(1'b1, 4'b0010, i, 8'($urandom));
    group_end("chr", 0, 1024, 0, 0);
    check_output("chr.err", err, 1);
    check_output("chr.loaded1", loaded[1], 0);

    do_reset("rst1");
    apply_stimulus(1'b1, 4'b0100, 0, 8'h11);
    apply_stimulus(1'b1, 4'b0100, 1, 8'h22);
    apply_stimulus(1'b1, 4'b0100, 2, 8'h33);
    apply_stimulus(1'b1, 4'b0100, 4, 8'h44);
    group_end("apu", 0, 0, 3, 0);
    check_output("apu.err", err, 1);
    check_output("apu.loaded2", loaded[2], 0);

    do_reset("rst2");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 4'b0110, i, 8'($urandom));
    @(negedge clk);
    check_output("multisel.busy", busy, 0);
    check_output("multisel.err", err, 1);
    group_end("multisel", 0, 0, 0, 0);

    do_reset("rst3");
    for (int r = 0; r < 40; r++) random_session();
    e0 = m_wr[0]; e1 = m_wr[1]; e2 = m_wr[2]; e3 = m_wr[3];
    group_end("rand", e0, e1, e2, e3);

    do_reset("rst4");
    for (int i = 0; i < 100; i++) apply_stimulus(1'b1, 4'b0001, i, 8'(i));
    do_reset("midload");
    group_end("midload", 100, 0, 0, 0);
    check_output("midload.loaded0", loaded[0], 0);

    for (int i = 5; i < 8; i++) apply_stimulus(1'b1, 4'b0001, i, 8'(i));
    group_end("postrst", 0, 0, 0, 0);
    check_output("postrst.err", err, 1);
    check_output("postrst.loaded", loaded, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scv_rominit_sink.md
SCV_ROMINIT_SINK -- requirements
Module: scv_rominit_sink

Interface
REQ-001 SHALL have parameter CART_AW, default 17, cartridge address width in bits (capacity 2^CART_AW bytes).
REQ-002 SHALL have parameter BOOT_BYTES, default 4096, boot ROM capacity in bytes.
REQ-003 SHALL have parameter CHR_BYTES, default 1024, character ROM capacity in bytes.
REQ-004 SHALL have parameter APU_BYTES, default 2048, APU ROM capacity in bytes.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RES  in  1  asynchronous, active-high reset.
REQ-007 SEL_BOOT, SEL_CHR, SEL_APU, SEL_CART  in  1 each  target selects.
REQ-008 ADDR  in  25  byte address of current beat.
REQ-009 DATA  in  8  byte of current beat.
REQ-010 VALID  in  1  beat qualifier; one byte per cycle while high.
REQ-011 BOOT_WE, CHR_WE, APU_WE, CART_WE  out  1 each  write strobes to target memories.
REQ-012 WADDR  out  CART_AW  registered write address.
REQ-013 WDATA  out  8  registered write data.
REQ-014 BUSY  out  1  session in progress.
REQ-015 LOADED  out  4  per-target load-complete flags {cart,apu,chr,boot}.
REQ-016 ERR  out  1  sticky protocol error.
REQ-017 CART_SIZE  out  CART_AW+1  bytes received in last good cart session.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DRAIN.
REQ-019 IDLE->LOAD on VALID=1 with exactly one SEL high; latch that target; set BUSY next cycle.
REQ-020 IDLE with VALID=1 and zero or several SELs high: no writes, set ERR, stay IDLE until VALID=0.
REQ-021 First beat of session SHALL have ADDR=0; otherwise set ERR, suppress all writes for the session.
REQ-022 Each later beat SHALL have ADDR = previous ADDR+1; on mismatch set ERR, suppress remainder of session.
REQ-023 Accepted beat in cycle N SHALL produce target WE=1, WADDR=ADDR[CART_AW-1:0], WDATA=DATA in cycle N+1 (latency 1); at most one WE high per cycle.
REQ-024 Beat with ADDR >= target capacity: WE suppressed, ERR set, session continues counting (overflow bytes discarded).
REQ-025 Latched target's SEL dropping, or another SEL rising, while VALID=1 SHALL abort: ERR set, no further writes, go DRAIN.
REQ-026 DRAIN SHALL ignore all beats until VALID=0, then IDLE.
REQ-027 LOAD->IDLE on VALID=0; if session error-free, set target's LOADED bit in the same cycle BUSY clears.
REQ-028 Good cart session end SHALL latch CART_SIZE = beat count (saturating at 2^CART_AW); errored cart session leaves CART_SIZE unchanged.
REQ-029 New session to a target SHALL clear its LOADED bit on entry to LOAD.
REQ-030 Beat counter SHALL be CART_AW+1 bits, saturating, never wrapping.
REQ-031 ERR SHALL clear only on reset.

Reset
REQ-032 RES=1 SHALL asynchronously force IDLE, all WE=0, WADDR=0, WDATA=0, BUSY=0, LOADED=0, ERR=0, CART_SIZE=0.
REQ-033 Reset mid-session SHALL abandon session without setting any LOADED bit; post-reset beats with VALID=1 and ADDR!=0 are treated per REQ-021.

Verification
REQ-034 SEL_BOOT, 4096 beats ADDR 0..4095 data=ADDR[7:0] -> 4096 BOOT_WE pulses, each one cycle after its beat, LOADED=4'b0001, ERR=0.
REQ-035 SEL_CART, 32768 beats -> CART_SIZE=32768, LOADED[3]=1, CART_WE count 32768, no other WE.
REQ-036 SEL_CHR, 1030 beats -> 1024 CHR_WE pulses, ERR=1, LOADED[1]=0.
REQ-037 SEL_APU with ADDR sequence 0,1,2,4 -> 3 APU_WE pulses, ERR=1, LOADED[2]=0.
REQ-038 SEL_CHR and SEL_APU both high with VALID=1 -> no WE, ERR=1, BUSY=0.
REQ-039 RES pulsed at beat 100 of boot load -> all outputs at reset values immediately, LOADED[0]=0 after reset.
